yd_lsu: RTL
===========

YD_LSU -- requirements
Module: yd_lsu

Interface
REQ-001 SHALL have parameter TO_CYC, default 8'd255, meaning bus wait-state limit in cycles before timeout.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port op_vld  input  1  decoder requests a memory op this cycle.
REQ-005 SHALL have port op_ld  input  1  1=load, 0=store.
REQ-006 SHALL have port op_rd  input  4  load destination register address (0=ZE, 1=DK, 2..14=R0..RC, 15=PC).
REQ-007 SHALL have port addr  input  16  byte-free word address, taken from register-file DKD.
REQ-008 SHALL have port st_data  input  16  store data, taken from register-file read port.
REQ-009 SHALL have port dsv  output  1  data-bus access indicator to register file; holds PC increment.
REQ-010 SHALL have ports wb_we/wb_addr/wb_data  output  1/4/16  register-file write port 1 (we1/waddr1/din1).
REQ-011 SHALL have ports bus_req/bus_we/bus_addr/bus_wdata  output  1/1/16/16  data-bus request.
REQ-012 SHALL have ports bus_ack/bus_rdata  input  1/16  data-bus completion and read data.
REQ-013 SHALL have ports err_clr input 1 and err output 1  sticky error flag and its clear.

Function
REQ-014 SHALL implement states IDLE, BUSY, WB.
REQ-015 In IDLE with op_vld=1 and valid op, SHALL latch op_ld, op_rd, addr, st_data and enter BUSY next cycle.
REQ-016 SHALL ignore op_vld in BUSY and WB; no queueing.
REQ-017 dsv SHALL be combinational: 1 when (IDLE and op_vld) or state=BUSY; 0 otherwise, including WB.
REQ-018 In BUSY, bus_req=1 and bus_we/bus_addr/bus_wdata SHALL equal latched values, stable until ack; bus_wdata=0 for loads.
REQ-019 bus_ack SHALL be sampled only when bus_req=1; ack in IDLE/WB ignored; earliest ack is first BUSY cycle.
REQ-020 On ack for store: next state IDLE. On ack for load: capture bus_rdata, next state WB.
REQ-021 In WB (exactly one cycle): wb_we=1, wb_addr=latched op_rd, wb_data=captured rdata; next state IDLE.
REQ-022 Load to op_rd=0 SHALL still perform bus access and WB cycle (register file discards).
REQ-023 Load with op_rd=15 (PC) SHALL be rejected in IDLE: no bus access, err set, state stays IDLE, dsv still 1 that cycle.
REQ-024 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; reaching TO_CYC SHALL drop bus_req, set err, return to IDLE, no writeback.
REQ-025 err SHALL be sticky; err_clr clears it; a simultaneous set and clear SHALL leave err=1.
REQ-026 Outside WB, wb_we=0, wb_addr=0, wb_data=0.
REQ-027 Latency: store = 1 + wait cycles; load = 2 + wait cycles from op acceptance to writeback completion.

Reset
REQ-028 With rst=1 at posedge: state=IDLE, counter=0, err=0, all latched fields 0; bus_req, bus_we, wb_we registered 0.
REQ-029 Reset mid-BUSY SHALL abandon the transaction; an ack arriving in the same cycle SHALL be discarded.
REQ-030 dsv SHALL be 0 while rst=1 regardless of op_vld.

Structure
REQ-031 Register address constants (ZEA=0, DKA=1, R0A=2, PCA=15) and state encoding SHALL live in shared package yd_pkg.
REQ-032 Wait counter and timeout compare SHALL be sub-module yd_lsu_timer (inputs clr, en; output expired).

Verification
REQ-033 Store addr=16'h0040, st_data=16'hBEEF, ack on 1st BUSY cycle -> bus_we=1, addr 0040, wdata BEEF, dsv high 2 cycles, no wb_we.
REQ-034 Load addr=16'h0100, op_rd=4'h3, ack after 3 wait cycles with rdata=16'h1234 -> wb_we=1 one cycle, wb_addr=3, wb_data=1234; dsv 0 in WB.
REQ-035 Load with op_rd=4'hF -> no bus_req, err=1, state IDLE; err_clr -> err=0.
REQ-036 TO_CYC=4, never ack -> bus_req drops after 4 BUSY cycles, err=1, no wb_we.
REQ-037 rst asserted in 2nd BUSY cycle with ack same cycle -> state IDLE, bus_req=0, wb_we never asserted.
REQ-038 op_vld held high during BUSY/WB with different addr -> second op accepted only after return to IDLE, using its own addr.

Source files
------------

// File: rtl/yd_pkg.sv
// Shared definitions for the YD load/store unit.
//   - Register-file address constants (ZE, DK, R0, PC)
//   - LSU state encoding
//   - Latched memory-op record
//   - op_legal(): screens out ops the LSU refuses to start
package yd_pkg;

    localparam logic [3:0] ZEA = 4'd0;   // zero register, writes discarded
    localparam logic [3:0] DKA = 4'd1;
    localparam logic [3:0] R0A = 4'd2;
    localparam logic [3:0] PCA = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        ld;
        logic [3:0]  rd;
        logic [15:0] addr;
        logic [15:0] wdata;
    } lsu_op_t;

    // A load into PC would redirect fetch behind the sequencer's back, so it
    // is refused before any bus traffic.
    function automatic logic op_legal(input logic ld, input logic [3:0] rd);
        return !(ld && (rd == PCA));
    endfunction

endpackage

// File: rtl/yd_lsu_timer.sv
// Bus wait-state timer for the LSU.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (pulsed when an op enters BUSY)
//   en       : count this cycle (BUSY without ack)
//   expired  : this counting cycle brings the count to TO_CYC
module yd_lsu_timer #(
    parameter logic [7:0] TO_CYC = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt + 8'd1;

    // Combinational so the FSM leaves BUSY on the very cycle the limit is
    // reached: exactly TO_CYC request cycles are issued before giving up.
    assign expired = en && (cnt_inc == TO_CYC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/yd_lsu.sv
// YD load/store unit: accepts one memory op from the decoder, runs it on the
// data bus, and writes load data back through register-file port 1.
//   clk, rst                       : clock, synchronous active-high reset
//   op_vld/op_ld/op_rd/addr/st_data: op request from decoder / register file
//   dsv                            : bus access in progress (holds PC increment)
//   wb_we/wb_addr/wb_data          : register-file write port 1
//   bus_req/bus_we/bus_addr/bus_wdata, bus_ack/bus_rdata : data bus
//   err_clr, err                   : sticky error (rejected op or bus timeout)
module yd_lsu
    import yd_pkg::*;
#(
    parameter logic [7:0] TO_CYC = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_vld,
    input  logic        op_ld,
    input  logic [3:0]  op_rd,
    input  logic [15:0] addr,
    input  logic [15:0] st_data,
    output logic        dsv,
    output logic        wb_we,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    input  logic        err_clr,
    output logic        err
);

    lsu_state_e  state, state_nxt;
    lsu_op_t     op_q;
    logic [15:0] rdata_q;
    logic        accept, reject, timeout;
    logic        busy_wait, expired;

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (op_vld) begin
                    if (op_legal(op_ld, op_rd)) begin
                        accept    = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            BUSY: begin
                // ack beats a same-cycle expiry: the transfer did complete
                if (bus_ack) begin
                    state_nxt = op_q.ld ? WB : IDLE;
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_wait = (state == BUSY) && !bus_ack;

    yd_lsu_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (busy_wait),
        .expired (expired)
    );

    // ---------------- state and latched fields ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            rdata_q <= 16'h0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q.ld    <= op_ld;
                op_q.rd    <= op_rd;
                op_q.addr  <= addr;
                op_q.wdata <= op_ld ? 16'h0 : st_data;  // loads drive zero wdata
            end
            if ((state == BUSY) && bus_ack && op_q.ld) begin
                rdata_q <= bus_rdata;
            end
            // set wins over a simultaneous clear
            if (reject || timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    // Everything is qualified with !rst so a reset cycle never shows an
    // access, even when it lands in the middle of one.
    assign dsv       = !rst && (((state == IDLE) && op_vld) || (state == BUSY));
    assign bus_req   = !rst && (state == BUSY);
    assign bus_we    = bus_req && !op_q.ld;
    assign bus_addr  = bus_req ? op_q.addr  : 16'h0;
    assign bus_wdata = bus_req ? op_q.wdata : 16'h0;

    assign wb_we     = !rst && (state == WB);
    assign wb_addr   = wb_we ? op_q.rd : 4'h0;
    assign wb_data   = wb_we ? rdata_q : 16'h0;

endmodule
